ms_timer_bank: RTL and testbench
================================

# ms_timer_bank

Millisecond timebase with a bank of NCH independently programmable countdown timers. Divides the system clock down to a 1-cycle `tick` at TICK_HZ, keeps a free-running wrapping tick counter `cnt`, and decrements each armed channel once per tick. Each channel raises a 1-cycle `expired` pulse at terminal count, then either stops (one-shot) or reloads (periodic). It serves as the shared timing source for timeout, debounce and periodic-event logic elsewhere in the design.

## Interface
- CLK_HZ, 50_000_000, clk frequency in Hz
- TICK_HZ, 1000, tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2 (elaboration-time check)
- CNT_W, 32, width of `cnt` and of channel counts
- NCH, 4, number of timer channels, >= 1; CH_W = max(1, $clog2(NCH))
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- en  input  1  prescaler enable; when low, prescaler, `cnt` and all channels hold
- ld_valid  input  1  load/arm request, sampled on every clk edge
- ld_ch  input  CH_W  channel to load
- ld_val  input  CNT_W  tick count until expiry, also the reload value
- ld_periodic  input  1  1 = periodic, 0 = one-shot
- cancel  input  1  disarm request
- cancel_ch  input  CH_W  channel to disarm
- tick  output  1  one-cycle tick pulse, registered
- cnt  output  CNT_W  free-running tick count, registered
- active  output  NCH  per-channel armed flag
- expired  output  NCH  per-channel one-cycle expiry pulse, registered

## Operation
- Reset: prescaler = 0, tick = 0, cnt = 0, active = 0, expired = 0, all remaining/reload = 0, periodic = 0.
- Prescaler: on an edge with en = 1, pre < DIV-1 → pre+1. pre == DIV-1 → pre = 0 and this is a tick edge. en = 0 → pre holds.
- Tick edge: tick <= 1, cnt <= cnt+1 mod 2^CNT_W (all-ones wraps to 0, no flag), and each active channel steps. Every other edge: tick <= 0.
- Channel step: remaining > 1 → remaining-1. remaining == 1 → expired[i] <= 1, then periodic → remaining <= reload, one-shot → active[i] <= 0.
- expired[i] is 0 on every edge that is not an expiry of channel i.
- Load, ld_valid = 1: ld_ch < NCH and ld_val != 0 → remaining = reload = ld_val, periodic = ld_periodic, active = 1. ld_ch >= NCH or ld_val == 0 → ignored. Re-loading an active channel restarts it.
- Cancel: cancel_ch < NCH → active = 0, remaining kept. Out-of-range cancel is ignored.
- Priority for one channel on one edge: cancel > load > tick step.
  - Cancel together with expiry: no expired pulse.
  - Load on a tick edge: no decrement in that cycle.
- Different channels are independent; load and cancel may target different channels on the same edge.
- Asynchronous reset mid-count returns everything to reset values immediately. The first tick after reset release needs a full DIV enabled cycles.

## Timing
- With en held high from reset release: tick is high in the cycle after the DIV-th rising edge, then every DIV cycles, 1 cycle wide.
- cnt, expired and active update on the same edge that raises tick.
- A channel loaded with N expires on the N-th tick edge after the load edge. Periodic channels then expire every N ticks.
- Latency: load to active = 1 edge; cancel to active low = 1 edge.

## Structure
- Package ms_timer_pkg:
  - function computing DIV;
  - typedef ch_state_t, a struct {remaining, reload, periodic, active}.
- Sub-module tick_prescaler (params CLK_HZ, TICK_HZ; ports clk, reset, en, tick_en): produces the internal tick strobe.
- Top level holds cnt and a generate loop of NCH channel blocks.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), CNT_W=8, NCH=4.
- Reset release, en=1, 35 cycles → tick pulses after edges 10, 20 and 30; cnt = 3; expired = 0.
- Load ch0 with 3 one-shot → expired[0] pulses once, on the 3rd tick edge; active[0] falls on the same edge; no further pulses.
- Load ch1 with 2 periodic → expired[1] on ticks 2, 4 and 6; active[1] stays 1.
- Cancel ch2 on its expiry edge → no expired[2] pulse. Load ch3 on a tick edge → no decrement; it expires N ticks later.
- Exercise cnt wrap and en gating:
  - Preload 255 ticks and run one more → cnt = 0.
  - en=0 for 50 cycles → pre, cnt and channels hold.
- Ignored requests: ld_val=0 → no change. ld_ch=5 with NCH=6 variant → valid. Assert reset mid-count → all outputs 0 at once.

Source files
------------

// File: rtl/ms_timer_pkg.sv
// Shared types and elaboration helpers for the millisecond timer bank.
package ms_timer_pkg;

    // Widest channel count supported; channel state is stored at this width
    // and only the low CNT_W bits are ever non-zero.
    localparam int MAX_CNT_W = 64;

    // Clock cycles per tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int calc_ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Per-channel countdown state.
    typedef struct packed {
        logic [MAX_CNT_W-1:0] remaining;
        logic [MAX_CNT_W-1:0] reload;
        logic                 periodic;
        logic                 active;
    } ch_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV and flags the cycle whose closing edge is a tick edge.
module tick_prescaler
    import ms_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick_en
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
        end
        if ((CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
            $error("tick_prescaler: CLK_HZ must be an integer multiple of TICK_HZ");
        end
    endgenerate

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Next prescaler value and the tick strobe; both freeze while en is low.
    always_comb begin
        pre_d   = pre_q;
        tick_en = 1'b0;
        if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                tick_en = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/ms_timer_bank.sv
// Millisecond timebase: free-running tick counter plus NCH countdown channels.
// Load/cancel are fire-and-forget strobes: a request is taken on every clk edge
// where its valid bit is high; there is no ready and nothing is ever stalled.
module ms_timer_bank
    import ms_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 32,
    parameter int NCH     = 4,
    localparam int CH_W   = calc_ch_w(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld_valid,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             ld_periodic,
    input  logic             cancel,
    input  logic [CH_W-1:0]  cancel_ch,
    output logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   expired
);

    generate
        if (NCH < 1) begin : g_bad_nch
            $error("ms_timer_bank: NCH must be at least 1");
        end
        if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
            $error("ms_timer_bank: CNT_W out of range");
        end
    endgenerate

    logic             tick_en;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .tick_en (tick_en)
    );

    // Registered tick pulse and wrapping tick counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tick_q <= tick_en;
            if (tick_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign tick = tick_q;
    assign cnt  = cnt_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t st_q;
        ch_state_t st_d;
        logic      exp_q;
        logic      exp_d;
        logic      ld_hit;
        logic      cancel_hit;

        // Index match alone rejects out-of-range channels; a zero count is never armed.
        assign ld_hit     = ld_valid && (ld_ch == CH_W'(i)) && (ld_val != '0);
        assign cancel_hit = cancel && (cancel_ch == CH_W'(i));

        // Channel next state: cancel beats load, load beats the tick step.
        always_comb begin
            st_d  = st_q;
            exp_d = 1'b0;
            if (cancel_hit) begin
                st_d.active = 1'b0;
            end else if (ld_hit) begin
                st_d.remaining = MAX_CNT_W'(ld_val);
                st_d.reload    = MAX_CNT_W'(ld_val);
                st_d.periodic  = ld_periodic;
                st_d.active    = 1'b1;
            end else if (tick_en && st_q.active) begin
                if (st_q.remaining > MAX_CNT_W'(1)) begin
                    st_d.remaining = st_q.remaining - MAX_CNT_W'(1);
                end else begin
                    exp_d = 1'b1;
                    if (st_q.periodic) begin
                        st_d.remaining = st_q.reload;
                    end else begin
                        st_d.active = 1'b0;
                    end
                end
            end
        end

        // Channel state and expiry pulse registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= '0;
                exp_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                exp_q <= exp_d;
            end
        end

        assign active[i]  = st_q.active;
        assign expired[i] = exp_q;
    end

endmodule

// File: tb/tb_ms_timer_bank.sv
// Directed bench for ms_timer_bank with DIV=10, CNT_W=8, NCH=4 (plus an NCH=6 instance).
module tb_ms_timer_bank;

    localparam int CH_W  = 2;
    localparam int CH6_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic en;
    always #5 clk = ~clk;

    // ---------------- DUT (NCH=4) ----------------
    logic            ld_valid;
    logic [CH_W-1:0] ld_ch;
    logic [7:0]      ld_val;
    logic            ld_periodic;
    logic            cancel;
    logic [CH_W-1:0] cancel_ch;
    logic            tick;
    logic [7:0]      cnt;
    logic [3:0]      active;
    logic [3:0]      expired;

    ms_timer_bank #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .CNT_W  (8),
        .NCH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ld_valid   (ld_valid),
        .ld_ch      (ld_ch),
        .ld_val     (ld_val),
        .ld_periodic(ld_periodic),
        .cancel     (cancel),
        .cancel_ch  (cancel_ch),
        .tick       (tick),
        .cnt        (cnt),
        .active     (active),
        .expired    (expired)
    );

    // ---------------- DUT (NCH=6) ----------------
    logic             ld6_valid;
    logic [CH6_W-1:0] ld6_ch;
    logic [7:0]       ld6_val;
    logic             ld6_periodic;
    logic             cancel6;
    logic [CH6_W-1:0] cancel6_ch;
    logic             tick6;
    logic [7:0]       cnt6;
    logic [5:0]       active6;
    logic [5:0]       expired6;

    ms_timer_bank #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .CNT_W  (8),
        .NCH    (6)
    ) dut6 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ld_valid   (ld6_valid),
        .ld_ch      (ld6_ch),
        .ld_val     (ld6_val),
        .ld_periodic(ld6_periodic),
        .cancel     (cancel6),
        .cancel_ch  (cancel6_ch),
        .tick       (tick6),
        .cnt        (cnt6),
        .active     (active6),
        .expired    (expired6)
    );

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        ld_valid     = 1'b0;
        ld_ch        = '0;
        ld_val       = '0;
        ld_periodic  = 1'b0;
        cancel       = 1'b0;
        cancel_ch    = '0;
        ld6_valid    = 1'b0;
        ld6_ch       = '0;
        ld6_val      = '0;
        ld6_periodic = 1'b0;
        cancel6      = 1'b0;
        cancel6_ch   = '0;
    endtask

    task automatic load(input int ch, input int val, input logic per);
        ld_valid    = 1'b1;
        ld_ch       = CH_W'(ch);
        ld_val      = 8'(val);
        ld_periodic = per;
    endtask

    // ---------------- directed sequence ----------------
    logic [3:0] exp_x;
    logic [3:0] exp_a;

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        clear_req();
        step();
        step();

        // Reset state
        check("rst_tick", 64'(tick), 64'(0));
        check("rst_cnt", 64'(cnt), 64'(0));
        check("rst_active", 64'(active), 64'(0));
        check("rst_expired", 64'(expired), 64'(0));
        check("rst_active6", 64'(active6), 64'(0));
        reset = 1'b0;

        // Free-running tick: pulses after edges 10, 20, 30
        for (int e = 1; e <= 35; e++) begin
            step();
            check("p1_tick", 64'(tick), 64'(e % 10 == 0));
            check("p1_cnt", 64'(cnt), 64'(e / 10));
        end
        check("p1_cnt_final", 64'(cnt), 64'(3));
        check("p1_expired", 64'(expired), 64'(0));

        // Channel scenarios, edge numbers counted from reset release
        for (int e = 36; e <= 135; e++) begin
            clear_req();
            case (e)
                36: load(0, 3, 1'b0);
                37: load(1, 2, 1'b1);
                80: load(0, 0, 1'b0);
                82: load(1, 0, 1'b1);
                96: load(2, 1, 1'b0);
                100: begin
                    load(3, 2, 1'b0);
                    cancel    = 1'b1;
                    cancel_ch = CH_W'(2);
                end
                default: ;
            endcase
            step();
            exp_x    = 4'b0000;
            exp_x[0] = (e == 60);
            exp_x[1] = (e == 50 || e == 70 || e == 90 || e == 110 || e == 130);
            exp_x[3] = (e == 120);
            exp_a    = 4'b0000;
            exp_a[0] = (e >= 36 && e < 60);
            exp_a[1] = (e >= 37);
            exp_a[2] = (e >= 96 && e < 100);
            exp_a[3] = (e >= 100 && e < 120);
            check("ch_tick", 64'(tick), 64'(e % 10 == 0));
            check("ch_cnt", 64'(cnt), 64'(e / 10));
            check("ch_expired", 64'(expired), 64'(exp_x));
            check("ch_active", 64'(active), 64'(exp_a));
        end
        clear_req();

        // en gating: everything holds
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            check("gate_tick", 64'(tick), 64'(0));
            check("gate_cnt", 64'(cnt), 64'(13));
            check("gate_active", 64'(active), 64'(4'b0010));
            check("gate_expired", 64'(expired), 64'(0));
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("resume_tick_low", 64'(tick), 64'(0));
        end
        step();
        check("resume_tick", 64'(tick), 64'(1));
        check("resume_cnt", 64'(cnt), 64'(14));
        check("resume_expired", 64'(expired), 64'(0));
        repeat (10) step();
        check("resume2_cnt", 64'(cnt), 64'(15));
        check("resume2_expired", 64'(expired), 64'(4'b0010));

        // cnt wrap
        repeat (2400) step();
        check("wrap_pre_cnt", 64'(cnt), 64'(255));
        check("wrap_pre_tick", 64'(tick), 64'(1));
        repeat (10) step();
        check("wrap_cnt", 64'(cnt), 64'(0));
        check("wrap_tick", 64'(tick), 64'(1));

        // Asynchronous reset mid-count
        repeat (13) step();
        check("mid_cnt", 64'(cnt), 64'(1));
        check("mid_active", 64'(active), 64'(4'b0010));
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", 64'(tick), 64'(0));
        check("arst_cnt", 64'(cnt), 64'(0));
        check("arst_active", 64'(active), 64'(0));
        check("arst_expired", 64'(expired), 64'(0));
        step();
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("post_rst_tick_low", 64'(tick), 64'(0));
        end
        step();
        check("post_rst_tick", 64'(tick), 64'(1));
        check("post_rst_cnt", 64'(cnt), 64'(1));

        // NCH=6 instance: range checks and ignored requests
        clear_req();
        ld6_valid = 1'b1; ld6_ch = 3'd6; ld6_val = 8'd1;
        step();
        check("n6_oor_load", 64'(active6), 64'(0));
        clear_req();
        ld6_valid = 1'b1; ld6_ch = 3'd5; ld6_val = 8'd3; ld6_periodic = 1'b1;
        step();
        check("n6_ch5_load", 64'(active6), 64'(6'b100000));
        clear_req();
        ld6_valid = 1'b1; ld6_ch = 3'd4; ld6_val = 8'd0;
        step();
        check("n6_zero_load", 64'(active6), 64'(6'b100000));
        clear_req();
        cancel6 = 1'b1; cancel6_ch = 3'd7;
        step();
        check("n6_oor_cancel", 64'(active6), 64'(6'b100000));
        clear_req();
        cancel6 = 1'b1; cancel6_ch = 3'd5;
        step();
        check("n6_cancel", 64'(active6), 64'(0));
        clear_req();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
